out_port_receiver: RTL

OUT_PORT_RECEIVER -- requirements
Module: out_port_receiver

---
 rtl/out_port_pkg.sv | 15 +
 rtl/out_fifo_mem.sv | 26 ++
 rtl/out_port_receiver.sv | 105 ++++++++++
 3 files changed

// File: rtl/out_port_pkg.sv
// Shared constants and helpers for the CPU output-port receiver FIFO.
// Imported by the receiver top level and its storage sub-module.
package out_port_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int DATA_W        = 8;
  localparam int FLAG_W        = 4;
  localparam int ENTRY_W       = 12;

  // Pointer width for a power-of-two depth, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/out_fifo_mem.sv
// Simple dual-port storage for the receiver FIFO.
// Writes are synchronous; the read port is asynchronous so the head entry falls through.
module out_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 12
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/out_port_receiver.sv
// Captures CPU output strobes into a first-word-fall-through FIFO for the host,
// with a hold request near full and a sticky overflow flag for dropped strobes.
module out_port_receiver
  import out_port_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int HOLD_MARGIN = 2
) (
  input  logic                       CLK,
  input  logic                       SYN_CLR,
  input  logic                       DOUT,
  input  logic [DATA_W-1:0]          OUT_RESULT,
  input  logic [FLAG_W-1:0]          FLAG_IN,
  input  logic                       HOST_READY,
  output logic                       HOST_VALID,
  output logic [DATA_W-1:0]          HOST_DATA,
  output logic [FLAG_W-1:0]          HOST_FLAG,
  output logic [ptr_width(DEPTH):0]  FIFO_COUNT,
  output logic                       CPU_HOLD,
  output logic                       OVERFLOW,
  input  logic                       OVF_CLR
);

  localparam int PTR_W = ptr_width(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t HOLD_C  = cnt_t'(HOLD_MARGIN);

  ptr_t wrPtr_q, wrPtr_d;
  ptr_t rdPtr_q, rdPtr_d;
  cnt_t count_q, count_d;
  logic overflow_q, overflow_d;

  logic full;
  logic pushEn;
  logic popEn;
  logic [ENTRY_W-1:0] rdData;

  // A push while full is only accepted when the head leaves on the same edge.
  always_comb begin
    full       = (count_q == DEPTH_C);
    popEn      = (count_q != '0) && HOST_READY;
    pushEn     = DOUT && (!full || popEn);
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (pushEn) begin
      wrPtr_d = wrPtr_q + ptr_t'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + ptr_t'(1);
    end

    case ({pushEn, popEn})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    if (DOUT && full && !popEn) begin
      overflow_d = 1'b1;
    end else if (OVF_CLR) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (SYN_CLR) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  out_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .WIDTH  (ENTRY_W)
  ) u_mem (
    .clk_i     (CLK),
    .wr_en_i   (pushEn && !SYN_CLR),
    .wr_addr_i (wrPtr_q),
    .wr_data_i ({FLAG_IN, OUT_RESULT}),
    .rd_addr_i (rdPtr_q),
    .rd_data_o (rdData)
  );

  assign HOST_VALID              = (count_q != '0);
  assign {HOST_FLAG, HOST_DATA}  = rdData;
  assign FIFO_COUNT              = count_q;
  assign CPU_HOLD                = ((DEPTH_C - count_q) <= HOLD_C);
  assign OVERFLOW                = overflow_q;

endmodule
